// File: rtl/mul28_column_compressor.sv
// Column compressor for a 28x28 unsigned multiplier: 55 equal-weight columns -> 56-bit product.
// Latency 1 cycle (2 cycles with MUL28_COMPRESSOR_PIPE_EN: sum/carry rows registered before the CPA).
// No backpressure: accepts one vector per cycle, valid_o is valid_i delayed by the latency.
module mul28_column_compressor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        src0,         input  logic [1:0]  src1,   input  logic [2:0]  src2,
    input  logic [3:0]  src3,         input  logic [4:0]  src4,   input  logic [5:0]  src5,
    input  logic [6:0]  src6,         input  logic [7:0]  src7,   input  logic [8:0]  src8,
    input  logic [9:0]  src9,         input  logic [10:0] src10,  input  logic [11:0] src11,
    input  logic [12:0] src12,        input  logic [13:0] src13,  input  logic [14:0] src14,
    input  logic [15:0] src15,        input  logic [16:0] src16,  input  logic [17:0] src17,
    input  logic [18:0] src18,        input  logic [19:0] src19,  input  logic [20:0] src20,
    input  logic [21:0] src21,        input  logic [22:0] src22,  input  logic [23:0] src23,
    input  logic [24:0] src24,        input  logic [25:0] src25,  input  logic [26:0] src26,
    input  logic [27:0] src27,        input  logic [26:0] src28,  input  logic [25:0] src29,
    input  logic [24:0] src30,        input  logic [23:0] src31,  input  logic [22:0] src32,
    input  logic [21:0] src33,        input  logic [20:0] src34,  input  logic [19:0] src35,
    input  logic [18:0] src36,        input  logic [17:0] src37,  input  logic [16:0] src38,
    input  logic [15:0] src39,        input  logic [14:0] src40,  input  logic [13:0] src41,
    input  logic [12:0] src42,        input  logic [11:0] src43,  input  logic [10:0] src44,
    input  logic [9:0]  src45,        input  logic [8:0]  src46,  input  logic [7:0]  src47,
    input  logic [6:0]  src48,        input  logic [5:0]  src49,  input  logic [4:0]  src50,
    input  logic [3:0]  src51,        input  logic [2:0]  src52,  input  logic [1:0]  src53,
    input  logic        src54,
    output logic        valid_o,
    output logic dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,  dst8,  dst9,
    output logic dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19,
    output logic dst20, dst21, dst22, dst23, dst24, dst25, dst26, dst27, dst28, dst29,
    output logic dst30, dst31, dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39,
    output logic dst40, dst41, dst42, dst43, dst44, dst45, dst46, dst47, dst48, dst49,
    output logic dst50, dst51, dst52, dst53, dst54, dst55
);

    // Number of 3:2 levels needed to bring 28 rows down to 2 (28,19,13,9,6,4,3,2).
    localparam int NLVL = 7;

    // Rows remaining after a given number of 3:2 levels.
    function automatic int rows_at(input int lvl);
        int n;
        n = 28;
        for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + n % 3;
        return n;
    endfunction

    logic [27:0] w_col [0:54];
    logic [55:0] w_pp  [0:27];
    logic [55:0] w_lv  [0:NLVL][0:27];
    logic [55:0] w_sum, w_carry, w_cpa;
    logic        w_cpa_vld;
    logic [55:0] r_prod;
    logic        r_vld;

    // Column bits zero-extended to the tallest column height.
    assign w_col[0]  = 28'(src0);  assign w_col[1]  = 28'(src1);  assign w_col[2]  = 28'(src2);
    assign w_col[3]  = 28'(src3);  assign w_col[4]  = 28'(src4);  assign w_col[5]  = 28'(src5);
    assign w_col[6]  = 28'(src6);  assign w_col[7]  = 28'(src7);  assign w_col[8]  = 28'(src8);
    assign w_col[9]  = 28'(src9);  assign w_col[10] = 28'(src10); assign w_col[11] = 28'(src11);
    assign w_col[12] = 28'(src12); assign w_col[13] = 28'(src13); assign w_col[14] = 28'(src14);
    assign w_col[15] = 28'(src15); assign w_col[16] = 28'(src16); assign w_col[17] = 28'(src17);
    assign w_col[18] = 28'(src18); assign w_col[19] = 28'(src19); assign w_col[20] = 28'(src20);
    assign w_col[21] = 28'(src21); assign w_col[22] = 28'(src22); assign w_col[23] = 28'(src23);
    assign w_col[24] = 28'(src24); assign w_col[25] = 28'(src25); assign w_col[26] = 28'(src26);
    assign w_col[27] = 28'(src27); assign w_col[28] = 28'(src28); assign w_col[29] = 28'(src29);
    assign w_col[30] = 28'(src30); assign w_col[31] = 28'(src31); assign w_col[32] = 28'(src32);
    assign w_col[33] = 28'(src33); assign w_col[34] = 28'(src34); assign w_col[35] = 28'(src35);
    assign w_col[36] = 28'(src36); assign w_col[37] = 28'(src37); assign w_col[38] = 28'(src38);
    assign w_col[39] = 28'(src39); assign w_col[40] = 28'(src40); assign w_col[41] = 28'(src41);
    assign w_col[42] = 28'(src42); assign w_col[43] = 28'(src43); assign w_col[44] = 28'(src44);
    assign w_col[45] = 28'(src45); assign w_col[46] = 28'(src46); assign w_col[47] = 28'(src47);
    assign w_col[48] = 28'(src48); assign w_col[49] = 28'(src49); assign w_col[50] = 28'(src50);
    assign w_col[51] = 28'(src51); assign w_col[52] = 28'(src52); assign w_col[53] = 28'(src53);
    assign w_col[54] = 28'(src54);

    // Transpose columns into 28 rows of 56-bit operands; bit r of column k lands in row r, bit k.
    always_comb begin
        for (int r = 0; r < 28; r++) begin
            w_pp[r] = '0;
            for (int k = 0; k < 55; k++) w_pp[r][k] = w_col[k][r];
        end
    end

    for (genvar r = 0; r < 28; r++) begin : g_row0
        assign w_lv[0][r] = w_pp[r];
    end

    // Wallace tree: each level groups rows in threes into sum/carry pairs, leftovers pass through.
    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        localparam int NI = rows_at(l);
        localparam int NG = NI / 3;
        localparam int NO = rows_at(l + 1);
        for (genvar g = 0; g < NG; g++) begin : g_fa
            logic [55:0] w_a, w_b, w_c;
            logic [54:0] w_maj;
            assign w_a   = w_lv[l][3*g];
            assign w_b   = w_lv[l][3*g+1];
            assign w_c   = w_lv[l][3*g+2];
            // Carry out of bit 55 falls off: the product is kept mod 2^56.
            assign w_maj = (w_a[54:0] & w_b[54:0]) | (w_a[54:0] & w_c[54:0]) | (w_b[54:0] & w_c[54:0]);
            assign w_lv[l+1][2*g]   = w_a ^ w_b ^ w_c;
            assign w_lv[l+1][2*g+1] = {w_maj, 1'b0};
        end
        for (genvar p = 0; p < NI - 3*NG; p++) begin : g_pass
            assign w_lv[l+1][2*NG+p] = w_lv[l][3*NG+p];
        end
        for (genvar z = NO; z < 28; z++) begin : g_zero
            assign w_lv[l+1][z] = '0;
        end
    end

    assign w_sum   = w_lv[NLVL][0];
    assign w_carry = w_lv[NLVL][1];

`ifdef MUL28_COMPRESSOR_PIPE_EN
    logic [55:0] r_sum, r_carry;
    logic        r_vld_p;

    // Register the two CSA rows so the carry-propagate add gets a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_vld_p <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
            r_vld_p <= valid_i;
        end
    end

    assign w_cpa     = r_sum + r_carry;
    assign w_cpa_vld = r_vld_p;
`else
    assign w_cpa     = w_sum + w_carry;
    assign w_cpa_vld = valid_i;
`endif

    // Output register: captures every cycle, valid only tags the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_prod <= w_cpa;
            r_vld  <= w_cpa_vld;
        end
    end

    assign valid_o = r_vld;
    assign {dst55, dst54, dst53, dst52, dst51, dst50, dst49, dst48, dst47, dst46,
            dst45, dst44, dst43, dst42, dst41, dst40, dst39, dst38, dst37, dst36,
            dst35, dst34, dst33, dst32, dst31, dst30, dst29, dst28, dst27, dst26,
            dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17, dst16,
            dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,  dst7,  dst6,
            dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = r_prod;

endmodule

// File: tb/tb_mul28_column_compressor.sv
// Testbench for mul28_column_compressor: directed table, reset sequences, random stream.
// Checks the product word and valid_o LAT cycles after each driven vector.
// Inputs are driven on the falling edge; outputs sampled on the falling edge.
module tb_mul28_column_compressor;

`ifdef MUL28_COMPRESSOR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NRAND = 1000;

    localparam int K_ZERO = 0, K_ALL = 1, K_S27 = 2, K_S1 = 3, K_CHAIN = 4, K_AB = 5;

    typedef struct {
        int          kind;
        logic [27:0] a;
        logic [27:0] b;
        logic [55:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    wire         valid_o;
    wire  [55:0] dst;
    logic [27:0] t_col [0:54];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wire [0:0]  src0  = t_col[0][0:0];   wire [1:0]  src1  = t_col[1][1:0];
    wire [2:0]  src2  = t_col[2][2:0];   wire [3:0]  src3  = t_col[3][3:0];
    wire [4:0]  src4  = t_col[4][4:0];   wire [5:0]  src5  = t_col[5][5:0];
    wire [6:0]  src6  = t_col[6][6:0];   wire [7:0]  src7  = t_col[7][7:0];
    wire [8:0]  src8  = t_col[8][8:0];   wire [9:0]  src9  = t_col[9][9:0];
    wire [10:0] src10 = t_col[10][10:0]; wire [11:0] src11 = t_col[11][11:0];
    wire [12:0] src12 = t_col[12][12:0]; wire [13:0] src13 = t_col[13][13:0];
    wire [14:0] src14 = t_col[14][14:0]; wire [15:0] src15 = t_col[15][15:0];
    wire [16:0] src16 = t_col[16][16:0]; wire [17:0] src17 = t_col[17][17:0];
    wire [18:0] src18 = t_col[18][18:0]; wire [19:0] src19 = t_col[19][19:0];
    wire [20:0] src20 = t_col[20][20:0]; wire [21:0] src21 = t_col[21][21:0];
    wire [22:0] src22 = t_col[22][22:0]; wire [23:0] src23 = t_col[23][23:0];
    wire [24:0] src24 = t_col[24][24:0]; wire [25:0] src25 = t_col[25][25:0];
    wire [26:0] src26 = t_col[26][26:0]; wire [27:0] src27 = t_col[27][27:0];
    wire [26:0] src28 = t_col[28][26:0]; wire [25:0] src29 = t_col[29][25:0];
    wire [24:0] src30 = t_col[30][24:0]; wire [23:0] src31 = t_col[31][23:0];
    wire [22:0] src32 = t_col[32][22:0]; wire [21:0] src33 = t_col[33][21:0];
    wire [20:0] src34 = t_col[34][20:0]; wire [19:0] src35 = t_col[35][19:0];
    wire [18:0] src36 = t_col[36][18:0]; wire [17:0] src37 = t_col[37][17:0];
    wire [16:0] src38 = t_col[38][16:0]; wire [15:0] src39 = t_col[39][15:0];
    wire [14:0] src40 = t_col[40][14:0]; wire [13:0] src41 = t_col[41][13:0];
    wire [12:0] src42 = t_col[42][12:0]; wire [11:0] src43 = t_col[43][11:0];
    wire [10:0] src44 = t_col[44][10:0]; wire [9:0]  src45 = t_col[45][9:0];
    wire [8:0]  src46 = t_col[46][8:0];  wire [7:0]  src47 = t_col[47][7:0];
    wire [6:0]  src48 = t_col[48][6:0];  wire [5:0]  src49 = t_col[49][5:0];
    wire [4:0]  src50 = t_col[50][4:0];  wire [3:0]  src51 = t_col[51][3:0];
    wire [2:0]  src52 = t_col[52][2:0];  wire [1:0]  src53 = t_col[53][1:0];
    wire [0:0]  src54 = t_col[54][0:0];

    mul28_column_compressor dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .valid_o(valid_o),
        .src0(src0),   .src1(src1),   .src2(src2),   .src3(src3),   .src4(src4),
        .src5(src5),   .src6(src6),   .src7(src7),   .src8(src8),   .src9(src9),
        .src10(src10), .src11(src11), .src12(src12), .src13(src13), .src14(src14),
        .src15(src15), .src16(src16), .src17(src17), .src18(src18), .src19(src19),
        .src20(src20), .src21(src21), .src22(src22), .src23(src23), .src24(src24),
        .src25(src25), .src26(src26), .src27(src27), .src28(src28), .src29(src29),
        .src30(src30), .src31(src31), .src32(src32), .src33(src33), .src34(src34),
        .src35(src35), .src36(src36), .src37(src37), .src38(src38), .src39(src39),
        .src40(src40), .src41(src41), .src42(src42), .src43(src43), .src44(src44),
        .src45(src45), .src46(src46), .src47(src47), .src48(src48), .src49(src49),
        .src50(src50), .src51(src51), .src52(src52), .src53(src53), .src54(src54),
        .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),
        .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),
        .dst10(dst[10]), .dst11(dst[11]), .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]),
        .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
        .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]), .dst24(dst[24]),
        .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]), .dst28(dst[28]), .dst29(dst[29]),
        .dst30(dst[30]), .dst31(dst[31]), .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]),
        .dst35(dst[35]), .dst36(dst[36]), .dst37(dst[37]), .dst38(dst[38]), .dst39(dst[39]),
        .dst40(dst[40]), .dst41(dst[41]), .dst42(dst[42]), .dst43(dst[43]), .dst44(dst[44]),
        .dst45(dst[45]), .dst46(dst[46]), .dst47(dst[47]), .dst48(dst[48]), .dst49(dst[49]),
        .dst50(dst[50]), .dst51(dst[51]), .dst52(dst[52]), .dst53(dst[53]), .dst54(dst[54]),
        .dst55(dst[55])
    );

    // Mask of the legal bits of column k (height k+1 rising, 55-k falling).
    function automatic logic [27:0] hmask(input int k);
        logic [27:0] m;
        int h;
        h = (k < 28) ? k + 1 : 55 - k;
        m = '0;
        for (int i = 0; i < h; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: weighted popcount of all columns, mod 2^56.
    function automatic logic [55:0] golden();
        logic [55:0] s;
        s = '0;
        for (int k = 0; k < 55; k++)
            s = s + (56'($countones(t_col[k] & hmask(k))) << k);
        return s;
    endfunction

    function automatic string kind_name(input int kind);
        case (kind)
            K_ZERO:  return "all_zero";
            K_ALL:   return "all_ones";
            K_S27:   return "single_src27";
            K_S1:    return "src1_11";
            K_CHAIN: return "carry_chain";
            default: return "partial_products";
        endcase
    endfunction

    task automatic clear_cols();
        for (int k = 0; k < 55; k++) t_col[k] = '0;
    endtask

    task automatic load_kind(input int kind, input logic [27:0] a, input logic [27:0] b);
        int cnt [0:54];
        clear_cols();
        for (int k = 0; k < 55; k++) cnt[k] = 0;
        case (kind)
            K_ALL:   for (int k = 0; k < 55; k++) t_col[k] = hmask(k);
            K_S27:   t_col[27] = 28'h1;
            K_S1:    t_col[1]  = 28'h3;
            K_CHAIN: for (int k = 0; k < 28; k++) t_col[k] = 28'h1 << (k / 2);
            K_AB: begin
                for (int i = 0; i < 28; i++)
                    for (int j = 0; j < 28; j++) begin
                        t_col[i+j][cnt[i+j]] = a[i] & b[j];
                        cnt[i+j] = cnt[i+j] + 1;
                    end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%014h, expected 0x%014h at %0t", nm, act, exp, $time);
        end
    endtask

    vec_t tbl [0:8];
    logic [55:0] hist_s [0:NRAND-1];
    logic        hist_v [0:NRAND-1];

    initial begin
        tbl[0] = '{K_ZERO,  28'h0,       28'h0,       56'h0};
        tbl[1] = '{K_ALL,   28'h0,       28'h0,       56'hFFFFFFE0000001};
        tbl[2] = '{K_S27,   28'h0,       28'h0,       56'h00000008000000};
        tbl[3] = '{K_S1,    28'h0,       28'h0,       56'h4};
        tbl[4] = '{K_CHAIN, 28'h0,       28'h0,       56'h0000000FFFFFFF};
        tbl[5] = '{K_AB,    28'hABCDEF1, 28'h1234567, 56'h0C379AA607A7F7};
        tbl[6] = '{K_AB,    28'h8000001, 28'h8000001, 56'h40000010000001};
        tbl[7] = '{K_AB,    28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
        tbl[8] = '{K_AB,    28'h0000001, 28'hFFFFFFF, 56'h0000000FFFFFFF};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        clear_cols();
        repeat (2) @(negedge clk);
        chk("reset_dst", dst, 56'h0);
        chk("reset_valid", {55'b0, valid_o}, 56'h0);

        // Fill the pipe with a nonzero valid result, then reset between edges.
        load_kind(K_ALL, 28'h0, 28'h0);
        valid_i = 1'b1;
        rst_n   = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk("pre_reset_dst", dst, 56'hFFFFFFE0000001);
        chk("pre_reset_valid", {55'b0, valid_o}, 56'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_dst", dst, 56'h0);
        chk("async_reset_valid", {55'b0, valid_o}, 56'h0);
        repeat (2) begin
            @(negedge clk);
            chk("held_reset_dst", dst, 56'h0);
            chk("held_reset_valid", {55'b0, valid_o}, 56'h0);
        end
        clear_cols();
        valid_i = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            chk("post_release_dst", dst, 56'h0);
            chk("post_release_valid", {55'b0, valid_o}, 56'h0);
        end

        // Directed table: one valid cycle each, result LAT cycles later, valid exactly one cycle.
        foreach (tbl[t]) begin
            load_kind(tbl[t].kind, tbl[t].a, tbl[t].b);
            valid_i = 1'b1;
            for (int i = 1; i <= LAT; i++) begin
                @(negedge clk);
                if (i == 1) valid_i = 1'b0;
            end
            chk(kind_name(tbl[t].kind), dst, tbl[t].exp);
            chk({kind_name(tbl[t].kind), "_valid"}, {55'b0, valid_o}, 56'h1);
            @(negedge clk);
            chk({kind_name(tbl[t].kind), "_valid_drop"}, {55'b0, valid_o}, 56'h0);
        end

        // Back-to-back random stream with random valid.
        for (int i = 0; i < NRAND + LAT; i++) begin
            if (i >= LAT) begin
                chk("stream_dst", dst, hist_s[i-LAT]);
                chk("stream_valid", {55'b0, valid_o}, {55'b0, hist_v[i-LAT]});
            end
            if (i < NRAND) begin
                for (int k = 0; k < 55; k++) t_col[k] = 28'($urandom()) & hmask(k);
                if ((i % 97) == 5) for (int k = 0; k < 55; k++) t_col[k] = hmask(k);
                valid_i   = 1'($urandom_range(0, 1));
                hist_s[i] = golden();
                hist_v[i] = valid_i;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end

        // Reset while a valid vector is in flight: it must be discarded.
        load_kind(K_AB, 28'hABCDEF1, 28'h1234567);
        valid_i = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midop_reset_dst", dst, 56'h0);
        chk("midop_reset_valid", {55'b0, valid_o}, 56'h0);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            chk("midop_discard_valid", {55'b0, valid_o}, 56'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
